// File: rtl/adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and chunk-count helpers.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int n_chunks(input int nb_bits, input int chunk);
    return nb_bits / chunk;
  endfunction

  // Counter must be at least one bit even when a single chunk covers the whole word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit chunks_ok(input int nb_bits, input int chunk);
    return (chunk >= 1) && (chunk <= nb_bits) && ((nb_bits % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; zero latency, no flow control.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  output logic             co,
  output logic [CHUNK-1:0] s,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci
);

  logic [CHUNK:0] sum;

  assign sum     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign {co, s} = sum;

endmodule

// File: rtl/multi_cycle_adder.sv
// Wide add/subtract computed CHUNK bits per cycle; done pulses N_CHUNKS cycles after acceptance.
// Backpressure: start is only taken while ready=1; requests during BUSY are dropped, not queued.
module multi_cycle_adder
  import adder_pkg::*;
#(
  parameter int NB_BITS = 16,
  parameter int CHUNK   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sub,
  input  logic [NB_BITS-1:0] a,
  input  logic [NB_BITS-1:0] b,
  input  logic               ci,
  output logic               ready,
  output logic               done,
  output logic [NB_BITS-1:0] s,
  output logic               co
);

  localparam int N_CHUNKS = n_chunks(NB_BITS, CHUNK);
  localparam int CNT_W    = cnt_width(N_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CHUNKS - 1);

  if (!chunks_ok(NB_BITS, CHUNK)) begin : g_bad_cfg
    $error("multi_cycle_adder: NB_BITS must be a non-zero multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [NB_BITS-1:0] a_q, a_d;
  logic [NB_BITS-1:0] b_q, b_d;
  logic               carry_q, carry_d;
  logic [NB_BITS-1:0] s_q, s_d;
  logic               co_q, co_d;
  logic [CNT_W-1:0]   idx_q, idx_d;

  logic [31:0]        base;
  logic [CHUNK-1:0]   a_chunk, b_chunk, sum_r;
  logic               sum_c;

  assign base    = 32'(idx_q) * 32'(CHUNK);
  assign a_chunk = a_q[base +: CHUNK];
  assign b_chunk = b_q[base +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .co (sum_c),
    .s  (sum_r),
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_q)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is folded into the operand: a + ~b + 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
          s_d     = '0;
          co_d    = 1'b0;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_d[base +: CHUNK] = sum_r;
        carry_d            = sum_c;
        if (idx_q == LAST_IDX) begin
          co_d    = sum_c;
          done_d  = 1'b1;
          ready_d = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign s     = s_q;
  assign co    = co_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Directed checks of the 16/4 adder, a 4/4 single-chunk instance and an exhaustive 8/2 sweep.
module tb_multi_cycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, sub, ci;
  logic [15:0] a, b;
  logic        ready, done, co;
  logic [15:0] s;

  logic       start4, sub4, ci4;
  logic [3:0] a4, b4, s4;
  logic       ready4, done4, co4;

  logic       start8, sub8, ci8;
  logic [7:0] b8;
  logic [7:0] a8 [16];
  logic [7:0] s8 [16];
  logic       co8 [16];
  logic       done8 [16];
  logic       ready8 [16];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int lat;
  int d0;
  logic rb;
  logic got;

  multi_cycle_adder #(.NB_BITS(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .ready(ready), .done(done), .s(s), .co(co)
  );

  multi_cycle_adder #(.NB_BITS(4), .CHUNK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4), .ci(ci4),
    .ready(ready4), .done(done4), .s(s4), .co(co4)
  );

  for (genvar k = 0; k < 16; k++) begin : g_sw
    multi_cycle_adder #(.NB_BITS(8), .CHUNK(2)) u (
      .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8[k]), .b(b8), .ci(ci8),
      .ready(ready8[k]), .done(done8[k]), .s(s8[k]), .co(co8[k])
    );
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start at the current negedge and returns at the negedge where done is seen.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                       input logic tsub, input bit poke, output int olat, output logic ordy);
    a = ta; b = tb_v; ci = tci; sub = tsub; start = 1'b1;
    olat = -1;
    ordy = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; ordy = ready;
        a = 16'hDEAD; b = 16'hBEEF; ci = 1'b1; sub = ~tsub;
      end
      if (poke && n == 2) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
      if (poke && n == 3) start = 1'b0;
      if (done) begin olat = n - 1; break; end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; ci4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; b8 = '0;
    for (int k = 0; k < 16; k++) a8[k] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_s",     32'(s),     32'h0);
    chk("rst_co",    32'(co),    32'h0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, rb);
    chk("ovf_lat",   32'(lat), 32'd4);
    chk("ovf_busy_ready", 32'(rb), 32'h0);
    chk("ovf_s",     32'(s),   32'h0000);
    chk("ovf_co",    32'(co),  32'h1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'h0);
    chk("hold_s",   32'(s),  32'h0000);
    chk("hold_co",  32'(co), 32'h1);

    d0 = done_cnt;
    do_op(16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b1, lat, rb);
    chk("add_lat", 32'(lat), 32'd4);
    chk("add_s",   32'(s),   32'h2222);
    chk("add_co",  32'(co),  32'h0);
    repeat (6) @(negedge clk);
    chk("busy_start_ignored", 32'(done_cnt - d0), 32'd1);
    chk("add_hold_s", 32'(s), 32'h2222);

    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, lat, rb);
    chk("sub_neg_s",  32'(s),  32'hFFFE);
    chk("sub_neg_co", 32'(co), 32'h0);
    chk("b2b_ready",  32'(ready), 32'h1);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, lat, rb);
    chk("b2b_lat",    32'(lat), 32'd4);
    chk("sub_pos_s",  32'(s),  32'h0002);
    chk("sub_pos_co", 32'(co), 32'h1);

    @(negedge clk);
    a = 16'h00AA; b = 16'h0055; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy_ready", 32'(ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(ready), 32'h1);
    chk("mid_rst_s",     32'(s),     32'h0);
    chk("mid_rst_co",    32'(co),    32'h0);
    chk("mid_rst_done",  32'(done),  32'h0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, lat, rb);
    chk("post_rst_s",  32'(s),  32'h0007);
    chk("post_rst_co", 32'(co), 32'h0);

    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; ci4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
    chk("w4_busy_ready", 32'(ready4), 32'h0);
    @(negedge clk);
    chk("w4_lat1_done", 32'(done4), 32'h1);
    chk("w4_s",  32'(s4),  32'h2);
    chk("w4_co", 32'(co4), 32'h1);
    a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    chk("w4_b2b_done", 32'(done4), 32'h1);
    chk("w4_b2b_s",  32'(s4),  32'h0);
    chk("w4_b2b_co", 32'(co4), 32'h1);

    for (int alo = 0; alo < 16; alo++) begin
      for (int bv = 0; bv < 256; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          for (int k = 0; k < 16; k++) a8[k] = 8'(k * 16 + alo);
          b8 = 8'(bv); ci8 = cv[0]; start8 = 1'b1;
          got = 1'b0;
          for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) start8 = 1'b0;
            if (done8[0]) begin got = 1'b1; break; end
          end
          chk("sweep8_done", 32'(got), 32'h1);
          for (int k = 0; k < 16; k++)
            chk("sweep8_sum", {23'b0, co8[k], s8[k]}, 32'(k * 16 + alo + bv + cv));
        end
      end
    end
    chk("sweep8_ready", 32'(ready8[0]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
